multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle RV32I core.
- Sequences the shared ALU, memory port, instruction register and register file over several cycles per instruction.
- Drives `alu_op_o[1:0]` into the ALU-control decoder (00 = ADD, 01 = SUB, 10 = decode from funct7/funct3).
- Waits on a ready/request handshake with the unified instruction/data memory.

Parameters:
- RESET_STATE_FETCH, 1, if 1 the FSM leaves reset in FETCH; if 0 it leaves reset in IDLE until `start_i`.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  synchronous active-low reset
- start_i  in  1  leaves IDLE (used only when RESET_STATE_FETCH=0)
- opcode_i  in  7  opcode field of the IR
- zero_i  in  1  ALU zero flag, valid in BEQ state
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request
- mem_write_o  out  1  request is a write
- adr_src_o  out  1  0 = PC, 1 = ALUOut
- ir_write_o  out  1  latch instruction and old PC
- pc_write_o  out  1  PC load
- reg_write_o  out  1  register file write
- alu_src_a_o  out  2  00 = PC, 01 = old PC, 10 = rs1 reg
- alu_src_b_o  out  2  00 = rs2 reg, 01 = imm, 10 = const 4
- alu_op_o  out  2  to ALU-control decoder
- result_src_o  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
- illegal_instr_o  out  1  one-cycle pulse on unsupported opcode
- busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: while `rst_ni`=0 all outputs are forced to 0.
  - On the clock edge sampled with `rst_ni`=0, state ← FETCH (or IDLE if RESET_STATE_FETCH=0).
  - Reset asserted mid-instruction abandons it; no write strobe may assert in that cycle.
- Outputs are combinational from state (Moore), except the terms that depend on `mem_ready_i` or `zero_i`, noted below. Unlisted outputs are 0. Decode of `opcode_i` happens only in DECODE.
- IDLE: all 0. Goes to FETCH when `start_i`=1.
- FETCH:
  - Asserts `mem_req_o`, `adr_src_o`=0, `alu_src_a_o`=00, `alu_src_b_o`=10, `alu_op_o`=00, `result_src_o`=10.
  - `ir_write_o` and `pc_write_o` equal `mem_ready_i`.
  - Holds while `mem_ready_i`=0; goes to DECODE when it is 1.
- DECODE:
  - Drives `alu_src_a_o`=01, `alu_src_b_o`=01, `alu_op_o`=00 (branch target precompute).
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADR
    - 1100011 → BEQ
    - 1101111 → JAL
    - anything else → pulse `illegal_instr_o`, go to FETCH, no writes.
- EXEC_R: `alu_src_a_o`=10, `alu_src_b_o`=00, `alu_op_o`=10 → ALU_WB.
- EXEC_I: `alu_src_a_o`=10, `alu_src_b_o`=01, `alu_op_o`=10 → ALU_WB.
- MEM_ADR: `alu_src_a_o`=10, `alu_src_b_o`=01, `alu_op_o`=00. Goes to MEM_RD for a load, MEM_WR for a store; opcode is registered in DECODE.
- MEM_RD: `mem_req_o`=1, `adr_src_o`=1. Holds until `mem_ready_i`, then → MEM_WB.
- MEM_WB: `result_src_o`=01, `reg_write_o`=1 → FETCH.
- MEM_WR: `mem_req_o`=1, `mem_write_o`=1, `adr_src_o`=1. Holds until `mem_ready_i`, then → FETCH.
- ALU_WB: `result_src_o`=00, `reg_write_o`=1 → FETCH.
- BEQ:
  - `alu_src_a_o`=10, `alu_src_b_o`=00, `alu_op_o`=01, `result_src_o`=00.
  - `pc_write_o` equals `zero_i`.
  - → FETCH.
- JAL: `alu_src_a_o`=01, `alu_src_b_o`=10, `alu_op_o`=00, `result_src_o`=00, `pc_write_o`=1 → ALU_WB.
- Latency with zero-wait memory:
  - 3 cycles: BEQ
  - 4 cycles: R, I, store, JAL
  - 5 cycles: load
  - Each memory wait cycle adds 1.
- `mem_req_o` stays asserted, with address/write type stable, until `mem_ready_i`. `mem_ready_i` is ignored in non-memory states.
- Illegal state encodings recover to FETCH on the next edge.

Optional Feature:
- Macro `MC_PERF_COUNTERS_EN`.
- When defined, adds outputs `cycle_cnt_o[31:0]` and `instret_cnt_o[31:0]`:
  - Both reset to 0.
  - `cycle_cnt_o` increments every cycle the FSM is not in IDLE.
  - `instret_cnt_o` increments on the final cycle of each legal instruction (transition back to FETCH, excluding illegal decode).
  - Both wrap from 0xFFFFFFFF to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then opcode 0110011 (add x3,x1,x2 = 0x002081B3) with `mem_ready_i`=1 → states FETCH/DECODE/EXEC_R/ALU_WB; `alu_op_o`=10 in EXEC_R; `reg_write_o`=1 only in cycle 4.
- Load 0x0000A183 with `mem_ready_i` low for 2 cycles in MEM_RD → 7 cycles total; `mem_req_o`, `adr_src_o`=1 held steady; `reg_write_o` only in MEM_WB.
- BEQ 0x00208463 with `zero_i`=1 and then `zero_i`=0 → `pc_write_o`=1 and 0 in BEQ, `alu_op_o`=01; both instructions take 3 cycles.
- Opcode 0x7F in DECODE → `illegal_instr_o` pulses for 1 cycle, then FETCH; no `reg_write_o`/`mem_write_o`/`pc_write_o` asserted.
- `rst_ni` dropped during MEM_WR with `mem_ready_i`=0 → all outputs 0 that cycle; FETCH on next edge.
- With `MC_PERF_COUNTERS_EN`: run add+beq+load (zero wait) → `instret_cnt_o`=3, `cycle_cnt_o`=12.

Source files
------------

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//   Main control FSM of the multicycle RV32I core. Sequences the shared ALU,
//   the unified instruction/data memory port, the instruction register and
//   the register file over several cycles per instruction.
//
// Parameters
//   RESET_STATE_FETCH : 1 = leave reset in FETCH, 0 = leave reset in IDLE
//                       and wait for start_i.
//
// Ports
//   clk_i           in   clock, rising edge
//   rst_ni          in   synchronous active-low reset (forces outputs to 0)
//   start_i         in   IDLE -> FETCH
//   opcode_i[6:0]   in   opcode field of the IR
//   zero_i          in   ALU zero flag (used in BEQ)
//   mem_ready_i     in   memory completes current request this cycle
//   mem_req_o       out  memory request
//   mem_write_o     out  request is a write
//   adr_src_o       out  0 = PC, 1 = ALUOut
//   ir_write_o      out  latch instruction and old PC
//   pc_write_o      out  PC load
//   reg_write_o     out  register file write
//   alu_src_a_o     out  00 = PC, 01 = old PC, 10 = rs1
//   alu_src_b_o     out  00 = rs2, 01 = imm, 10 = const 4
//   alu_op_o        out  00 = ADD, 01 = SUB, 10 = funct decode
//   result_src_o    out  00 = ALUOut, 01 = mem data, 10 = ALU result
//   illegal_instr_o out  one-cycle pulse on unsupported opcode
//   busy_o          out  high in every state except IDLE
//
// Optional feature (macro MC_PERF_COUNTERS_EN)
//   cycle_cnt_o[31:0]   cycles spent outside IDLE
//   instret_cnt_o[31:0] legal instructions retired
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int RESET_STATE_FETCH = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [6:0] opcode_i,
    input  logic       zero_i,
    input  logic       mem_ready_i,
    output logic       mem_req_o,
    output logic       mem_write_o,
    output logic       adr_src_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       reg_write_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] result_src_o,
    output logic       illegal_instr_o,
    output logic       busy_o
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0] cycle_cnt_o,
    output logic [31:0] instret_cnt_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC_R  = 4'd3,
        S_EXEC_I  = 4'd4,
        S_MEM_ADR = 4'd5,
        S_MEM_RD  = 4'd6,
        S_MEM_WB  = 4'd7,
        S_MEM_WR  = 4'd8,
        S_ALU_WB  = 4'd9,
        S_BEQ     = 4'd10,
        S_JAL     = 4'd11
    } state_t;

    localparam state_t RST_STATE = (RESET_STATE_FETCH != 0) ? S_FETCH : S_IDLE;

    state_t     r_state;
    state_t     w_next;
    logic       r_is_store;

    logic       w_mem_req, w_mem_write, w_adr_src, w_ir_write, w_pc_write;
    logic       w_reg_write, w_illegal, w_busy;
    logic [1:0] w_alu_src_a, w_alu_src_b, w_alu_op, w_result_src;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= RST_STATE;
        end else begin
            r_state <= w_next;
        end
    end

    // Load vs store only differ in opcode bit 5; capture it while the IR
    // opcode is being decoded so MEM_ADR does not depend on opcode_i.
    always_ff @(posedge clk_i) begin
        if (r_state == S_DECODE) begin
            r_is_store <= opcode_i[5];
        end
    end

    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_mem_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        w_result_src = 2'b00;
        w_illegal    = 1'b0;
        w_busy       = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start_i) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_req    = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = mem_ready_i;
                w_pc_write   = mem_ready_i;
                if (mem_ready_i) w_next = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch target from old PC + imm.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                case (opcode_i)
                    7'b0110011:             w_next = S_EXEC_R;
                    7'b0010011:             w_next = S_EXEC_I;
                    7'b0000011, 7'b0100011: w_next = S_MEM_ADR;
                    7'b1100011:             w_next = S_BEQ;
                    7'b1101111:             w_next = S_JAL;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_EXEC_I: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
                w_next      = S_ALU_WB;
            end
            S_MEM_ADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_next      = r_is_store ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_adr_src = 1'b1;
                if (mem_ready_i) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                w_adr_src   = 1'b1;
                if (mem_ready_i) w_next = S_FETCH;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_pc_write  = zero_i;
                w_next      = S_FETCH;
            end
            S_JAL: begin
                // ALU computes the link address (old PC + 4) for ALU_WB.
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_write  = 1'b1;
                w_next      = S_ALU_WB;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    // Reset masks every output so an abandoned instruction cannot write.
    assign mem_req_o       = rst_ni & w_mem_req;
    assign mem_write_o     = rst_ni & w_mem_write;
    assign adr_src_o       = rst_ni & w_adr_src;
    assign ir_write_o      = rst_ni & w_ir_write;
    assign pc_write_o      = rst_ni & w_pc_write;
    assign reg_write_o     = rst_ni & w_reg_write;
    assign alu_src_a_o     = rst_ni ? w_alu_src_a  : 2'b00;
    assign alu_src_b_o     = rst_ni ? w_alu_src_b  : 2'b00;
    assign alu_op_o        = rst_ni ? w_alu_op     : 2'b00;
    assign result_src_o    = rst_ni ? w_result_src : 2'b00;
    assign illegal_instr_o = rst_ni & w_illegal;
    assign busy_o          = rst_ni & w_busy;

`ifdef MC_PERF_COUNTERS_EN
    logic        w_retire;
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    // Retirement is the last state of a legal instruction heading to FETCH;
    // illegal decode also returns to FETCH but is excluded by state.
    assign w_retire = (w_next == S_FETCH) &&
                      ((r_state == S_MEM_WB) || (r_state == S_ALU_WB) ||
                       (r_state == S_BEQ)    || (r_state == S_MEM_WR));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            if (r_state != S_IDLE) r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (w_retire) r_instret_cnt <= r_instret_cnt + 32'd1;
        end
    end

    assign cycle_cnt_o   = r_cycle_cnt;
    assign instret_cnt_o = r_instret_cnt;
`endif

endmodule
